// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Purpose:
//   Time-shares the 4-bit seven-segment display path between up to four
//   producers. It grants one requester at a time with round-robin fairness,
//   latches the granted nibble, and holds it on the display for HOLD_CYCLES.
//   It then blanks the display for GAP_CYCLES before the next grant is
//   considered.
//
// Parameters:
//   NUM_SRC      number of requesters (2..4)
//   HOLD_CYCLES  dwell time per value in clock cycles (>= 1)
//   GAP_CYCLES   blank time between values in clock cycles (0 = no gap)
//
// Ports:
//   clock_10Mhz    in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   req_valid      in   [NUM_SRC]   per-source request
//   req_data       in   [4*NUM_SRC] source i nibble at [4i+3:4i]
//   req_ready      out  [NUM_SRC]   one-hot accept (combinational, IDLE only)
//   skip           in   ends the current SHOW dwell early
//   display_data   out  [4]         nibble to the display controller
//   display_valid  out  high while a value is shown, low means blank
//   active_src     out  [2]         index of the source currently/last shown
//   busy           out  high in SHOW or GAP (registered)
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
  parameter int NUM_SRC     = 3,
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic                 clock_10Mhz,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   req_valid,
  input  logic [4*NUM_SRC-1:0] req_data,
  output logic [NUM_SRC-1:0]   req_ready,
  input  logic                 skip,
  output logic [3:0]           display_data,
  output logic                 display_valid,
  output logic [1:0]           active_src,
  output logic                 busy
);

  // Counter is sized for the longer of the two timed states; it counts
  // 0..N-1 inside a state and is cleared on every exit, so it never wraps.
  localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HG > 2) ? CNT_MAX_HG : 2;
  localparam int CNT_W      = $clog2(CNT_MAX);

  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LAST_I);
  localparam logic [1:0]       GRANT_INIT = 2'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       last_grant_reg;
  logic [3:0]       data_reg;
  logic             valid_reg;
  logic [1:0]       src_reg;
  logic             busy_reg;

  // Arbiter results
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [3:0]       grant_data;

  // Decoded events
  logic             transfer;
  logic             show_done;
  logic             gap_done;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: scan starting at last_grant+1 and take the first
  // valid source. Only indices below NUM_SRC are ever visited, so
  // nonexistent sources can never be granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      if (!grant_found && req_valid[(int'(last_grant_reg) + 1 + off) % NUM_SRC]) begin
        grant_found = 1'b1;
        grant_idx   = 2'((int'(last_grant_reg) + 1 + off) % NUM_SRC);
        grant_data  = req_data[4*((int'(last_grant_reg) + 1 + off) % NUM_SRC) +: 4];
      end
    end
  end

  // A transfer only happens in IDLE. Gating with reset keeps the reset
  // cycle from both accepting a request and showing a ready pulse.
  assign transfer  = (state_reg == ST_IDLE) && grant_found && !reset;

  // Expiry and skip in the same cycle collapse into one exit.
  assign show_done = (state_reg == ST_SHOW) && (skip || (cnt_reg == HOLD_LAST));
  assign gap_done  = (state_reg == ST_GAP) && (cnt_reg == GAP_LAST);

  // ---------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_10Mhz) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= GRANT_INIT;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      src_reg        <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // The nibble and source are only updated on a grant, so they are
      // retained through GAP and IDLE.
      if (transfer) begin
        data_reg       <= grant_data;
        src_reg        <= grant_idx;
        last_grant_reg <= grant_idx;
      end
      valid_reg <= (state_next == ST_SHOW);
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (show_done) begin
          state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_next = '0;
    if (((state_reg == ST_SHOW) && !show_done) ||
        ((state_reg == ST_GAP) && !gap_done)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  // One-hot ready on the winning source. The ready path depends only on the
  // state, the request vector and reset; skip never reaches it.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign req_ready[gi] = transfer && (grant_idx == 2'(gi));
  end

  always_comb begin
    display_data  = data_reg;
    display_valid = valid_reg;
    active_src    = src_reg;
    busy          = busy_reg;
  end

endmodule
